// File: rtl/tone_pkg.sv
`default_nettype none
// tone_pkg: shared types and constants for the tone/alarm generator. Rev 1.0
package tone_pkg;
  typedef enum logic [1:0] {SAW = 2'd0, SQUARE = 2'd1, TRIANGLE = 2'd2, MODE3 = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_e;
  localparam int VOL_W = 4;
endpackage
`default_nettype wire

// File: rtl/tone_tick_gen.sv
`default_nettype none
// tone_tick_gen: free-running prescaler, one-cycle tick every PRESCALE clk while run is high. Rev 1.0
module tone_tick_gen #(
  parameter int PRESCALE = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] count;

  assign tick = run && (count == CW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/tone_alarm_generator.sv
`default_nettype none
// tone_alarm_generator: tick-driven phase-accumulator tone with ON/OFF burst cadence into a unipolar DAC.
// Optional macro SIREN_EN turns mode 3 into a swept square siren (otherwise mode 3 is silent). Rev 1.0
module tone_alarm_generator
  import tone_pkg::*;
#(
  parameter int DAC_W     = 8,
  parameter int PHASE_W   = 16,
  parameter int PRESCALE  = 256,
  parameter int ON_TICKS  = 4096,
  parameter int OFF_TICKS = 4096,
  parameter int BURST_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [VOL_W-1:0]   volume,
  input  logic [BURST_W-1:0] burst_count,
  output logic [DAC_W-1:0]   DAC,
  output logic               busy,
  output logic               done
);
  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  state_e             state;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_inc;
  logic [CNT_W-1:0]   interval;
  logic [BURST_W-1:0] bursts;
  logic               tick;
  logic [DAC_W-1:0]   sample_now;
  logic [DAC_W-1:0]   sample_inc;

  tone_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (busy),
    .tick  (tick)
  );

  function automatic logic [DAC_W-1:0] shape(input logic [PHASE_W-1:0] ph,
                                             input logic [1:0]         m,
                                             input logic [VOL_W-1:0]   vol);
    logic [DAC_W-1:0] p;
    logic [DAC_W-1:0] w;
    logic [DAC_W+4:0] prod;
    p = ph[PHASE_W-1 -: DAC_W];
    case (mode_e'(m))
      SAW:      w = p;
      SQUARE:   w = {DAC_W{p[DAC_W-1]}};
      TRIANGLE: w = p[DAC_W-1] ? ~{p[DAC_W-2:0], 1'b0} : {p[DAC_W-2:0], 1'b0};
`ifdef SIREN_EN
      default:  w = {DAC_W{p[DAC_W-1]}};
`else
      default:  w = '0;
`endif
    endcase
    prod = {5'b0, w} * ({{(DAC_W + 1){1'b0}}, vol} + (DAC_W + 5)'(1));
    return DAC_W'(prod >> 4);
  endfunction

`ifdef SIREN_EN
  logic [PHASE_W-1:0] sweep;
  logic [PHASE_W-1:0] sweep_shr;
  logic [PHASE_W-1:0] sweep_step;
  logic [PHASE_W:0]   sweep_sum;

  always_comb begin
    sweep_shr  = freq_word >> 6;
    sweep_step = (sweep_shr == '0) ? PHASE_W'(1) : sweep_shr;
    sweep_sum  = {1'b0, sweep} + {1'b0, sweep_step};
    phase_inc  = phase + freq_word + ((mode == MODE3) ? sweep : '0);
  end

  // Sweep restarts from zero every time the tone (re)enters ON.
  always_ff @(posedge clk) begin
    if (reset || stop || state != ON) begin
      sweep <= '0;
    end else if (tick) begin
      sweep <= (sweep_sum >= {1'b0, freq_word}) ? '0 : sweep_sum[PHASE_W-1:0];
    end
  end
`else
  assign phase_inc = phase + freq_word;
`endif

  // DAC is loaded with the sample of the phase that will hold after this edge.
  assign sample_now = shape(phase, mode, volume);
  assign sample_inc = shape(phase_inc, mode, volume);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      interval <= '0;
      bursts   <= '0;
      DAC      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        phase    <= '0;
        interval <= '0;
        DAC      <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            DAC <= '0;
            if (start) begin
              state    <= ON;
              busy     <= 1'b1;
              bursts   <= burst_count;
              interval <= '0;
              phase    <= '0;
            end
          end
          ON: begin
            DAC <= sample_now;
            if (tick) begin
              phase <= phase_inc;
              DAC   <= sample_inc;
              if (bursts != '0 && interval == CNT_W'(ON_TICKS - 1)) begin
                state    <= OFF;
                interval <= '0;
                DAC      <= '0;
              end else begin
                interval <= interval + CNT_W'(1);
              end
            end
          end
          OFF: begin
            DAC <= '0;
            if (tick) begin
              if (interval == CNT_W'(OFF_TICKS - 1)) begin
                interval <= '0;
                bursts   <= bursts - BURST_W'(1);
                if (bursts == BURST_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  phase <= '0;
                end else begin
                  state <= ON;
                  DAC   <= sample_now;
                end
              end else begin
                interval <= interval + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            DAC   <= '0;
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_tone_alarm_generator.sv
`default_nettype none
// tb_tone_alarm_generator: scoreboard bench; expected samples come from a closed-form cadence model. Rev 1.0
module tb_tone_alarm_generator;
  localparam int DAC_W    = 8;
  localparam int PHASE_W  = 16;
  localparam int PRESCALE = 4;
  localparam int ON_T     = 8;
  localparam int OFF_T    = 4;
  localparam int BURST_W  = 4;
  localparam int PERIOD   = ON_T + OFF_T;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [PHASE_W-1:0] freq_word = '0;
  logic [3:0]         volume = 4'd0;
  logic [BURST_W-1:0] burst_count = '0;
  logic [DAC_W-1:0]   DAC;
  logic               busy;
  logic               done;

  tone_alarm_generator #(
    .DAC_W(DAC_W), .PHASE_W(PHASE_W), .PRESCALE(PRESCALE),
    .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .freq_word(freq_word), .volume(volume), .burst_count(burst_count),
    .DAC(DAC), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  dac;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bit          active = 1'b0;
  int unsigned seq_s = 0;
  int unsigned seq_b = 0;
  int unsigned seq_f = 0;

  function automatic int unsigned shape_ref(int unsigned p, int unsigned m, int unsigned vol);
    int unsigned w;
    case (m)
      0:       w = p;
      1:       w = (p >= 128) ? 255 : 0;
      2:       w = (p < 128) ? 2 * p : 255 - ((2 * p) % 256);
      default: w = 0;
    endcase
    return (w * (vol + 1)) / 16;
  endfunction

  // Expected outputs after posedge c: ticks elapsed, position in the cadence, and
  // the number of ON ticks so far determine the phase directly.
  function automatic exp_t model(int unsigned c);
    exp_t        e;
    int unsigned n, k, j, ont, ph;
    bit          on;
    e.cyc = c; e.dac = 8'h00; e.busy = 1'b0; e.done = 1'b0;
    if (active) begin
      n = c - seq_s;
      if (seq_b != 0 && n == PERIOD * seq_b * PRESCALE) begin
        e.done = 1'b1;
      end else begin
        e.busy = 1'b1;
        k = n / PRESCALE;
        if (seq_b == 0) begin
          on = 1'b1; ont = k;
        end else begin
          j   = k % PERIOD;
          on  = (j < ON_T);
          ont = ON_T * (k / PERIOD) + (on ? j : ON_T);
        end
        ph = (seq_f * ont) % 65536;
        if (on) e.dac = 8'(shape_ref(ph >> 8, int'(mode), int'(volume)));
      end
    end
    return e;
  endfunction

  task automatic step(input bit st, input bit sp, input bit rs);
    int unsigned c1;
    c1    = cyc + 1;
    start = st; stop = sp; reset = rs;
    if (active && seq_b != 0 && (cyc - seq_s) >= PERIOD * seq_b * PRESCALE) active = 1'b0;
    if (rs || sp) begin
      active = 1'b0;
    end else if (st && !active) begin
      active = 1'b1; seq_s = c1; seq_b = int'(burst_count); seq_f = int'(freq_word);
    end
    sbq.push_back(model(c1));
    @(negedge clk);
  endtask

  exp_t e;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc != cyc) begin
        checks++; errors++;
        $display("FAIL stale_entry cyc %0d entry for cyc %0d", cyc, e.cyc);
      end else begin
        checks++;
        if (DAC !== e.dac) begin
          errors++; $display("FAIL dac cyc %0d got %h want %h", cyc, DAC, e.dac);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++; $display("FAIL busy cyc %0d got %b want %b", cyc, busy, e.busy);
        end
        checks++;
        if (done !== e.done) begin
          errors++; $display("FAIL done cyc %0d got %b want %b", cyc, done, e.done);
        end
      end
    end
  end

  int len;
  int r;
  initial begin
    repeat (2) @(negedge clk);
    repeat (3) step(0, 0, 1);
    // continuous sawtooth, then stop
    mode = 2'd0; freq_word = 16'h1000; volume = 4'd15; burst_count = 4'd0;
    step(1, 0, 0); repeat (80) step(0, 0, 0); step(0, 1, 0); repeat (3) step(0, 0, 0);
    // start and stop together in idle
    step(1, 1, 0); repeat (4) step(0, 0, 0);
    // two-burst square at volume 7, with an ignored start while busy
    mode = 2'd1; freq_word = 16'h4000; volume = 4'd7; burst_count = 4'd2;
    step(1, 0, 0); repeat (10) step(0, 0, 0);
    burst_count = 4'd9; step(1, 0, 0); repeat (100) step(0, 0, 0);
    // stop in the middle of OFF
    burst_count = 4'd1; mode = 2'd2; freq_word = 16'h0C00;
    step(1, 0, 0); repeat (38) step(0, 0, 0); step(0, 1, 0); repeat (20) step(0, 0, 0);
    // reset mid-ON, then a fresh start
    mode = 2'd0; freq_word = 16'h2000;
    step(1, 0, 0); repeat (13) step(0, 0, 0); step(0, 0, 1);
    step(1, 0, 0); repeat (60) step(0, 0, 0);
`ifndef SIREN_EN
    mode = 2'd3; burst_count = 4'd1; freq_word = 16'h1234;
    step(1, 0, 0); repeat (55) step(0, 0, 0);
`endif
    for (int s = 0; s < 25; s++) begin
`ifdef SIREN_EN
      mode = 2'($urandom_range(0, 2));
`else
      mode = 2'($urandom_range(0, 3));
`endif
      freq_word   = 16'($urandom);
      volume      = 4'($urandom);
      burst_count = 4'($urandom_range(0, 3));
      len         = int'($urandom_range(10, 200));
      step(1, 0, 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) volume = 4'($urandom);
        r = int'($urandom_range(0, 99));
        step(r < 3, r == 3, r == 4);
      end
      step(0, 1, 0); step(0, 0, 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
